comm_master_q: RTL and testbench

Parametrised, queued successor to the single-shot wireless command master used by the copter bench and ground-station logic. Accepts command frames (8-bit opcode plus DATA_BYTES of payload) into a FIFO, serialises each over an internal 8N1 UART, then waits for the copter's single response byte or a timeout before issuing the next frame. Sits between host/test logic and the RX/TX wireless link pins of the QuadCopter DUT.

---
 rtl/comm_master_q.sv | 176 +++++++++++++++++
 tb/tb_comm_master_q.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comm_master_q.sv
// comm_master_q: queued command-frame master over an 8N1 UART, one response byte or timeout per frame.
// Defining COMM_MASTER_Q_CHKSUM_EN appends a two's-complement checksum byte to every frame.
module comm_master_q #(
    parameter int DATA_BYTES   = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int BAUD_DIV     = 2604,
    parameter int RESP_TIMEOUT = 500000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    cmd,
    input  logic [8*DATA_BYTES-1:0]       data,
    input  logic                          snd_cmd,
    output logic                          cmd_full,
    output logic                          ovfl,
    output logic [$clog2(FIFO_DEPTH):0]   pending,
    output logic                          busy,
    output logic                          TX,
    input  logic                          RX,
    output logic                          frm_snt,
    output logic [7:0]                    resp,
    output logic                          resp_rdy,
    input  logic                          clr_resp_rdy,
    output logic                          timeout
);
`ifdef COMM_MASTER_Q_CHKSUM_EN
    localparam int F = DATA_BYTES + 2;
`else
    localparam int F = DATA_BYTES + 1;
`endif
    localparam int FW = 8 + 8 * DATA_BYTES;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BAUD_DIV);
    localparam int TW = $clog2(RESP_TIMEOUT + 1);
    localparam int IW = $clog2(F);
    localparam logic [BW-1:0] B_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] B_HALF = BW'(BAUD_DIV / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(RESP_TIMEOUT - 1);
    localparam logic [IW-1:0] I_LAST = IW'(F - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT_RESP} state_t;
    state_t state, state_nxt;

    logic [FW-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic           push, pop;
    logic [FW-1:0]  head;
    logic [8*F-1:0] frame_in, frm;
    logic [7:0]     cur;
    logic [BW-1:0]  bcnt, rcnt;
    logic [3:0]     bit_i, rbit;
    logic [IW-1:0]  byte_i;
    logic [TW-1:0]  tcnt;
    logic           bit_end, frame_end, tmo_hit;
    logic [1:0]     sync;
    logic           rx_s, rx_prev, rx_on, r_end, rx_done;
    logic [7:0]     rx_sh;

    assign cmd_full  = count == (AW + 1)'(FIFO_DEPTH);
    assign pending   = count;
    assign busy      = state != IDLE;
    assign push      = snd_cmd && !cmd_full;
    // An empty FIFO being written this cycle is popped at once so LOAD follows the push directly.
    assign pop       = state == IDLE && (count != '0 || push);
    assign head      = mem[rd_ptr - AW'(1)];
    assign cur       = frm[8*F-1 -: 8];
    assign bit_end   = bcnt == B_LAST;
    assign frame_end = bit_end && bit_i == 4'd9 && byte_i == I_LAST;
    assign tmo_hit   = state == WAIT_RESP && tcnt == T_LAST;
    assign rx_s      = sync[1];
    assign r_end     = rbit == 4'd0 ? rcnt == B_HALF : rcnt == B_LAST;
    assign rx_done   = rx_on && r_end && rbit == 4'd9 && rx_s;

`ifdef COMM_MASTER_Q_CHKSUM_EN
    logic [7:0] sum;
    always_comb begin
        sum = '0;
        for (int i = 0; i <= DATA_BYTES; i++) sum = sum + head[8*i +: 8];
    end
    assign frame_in = {head, 8'h00 - sum};
`else
    assign frame_in = head;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = pop ? LOAD : IDLE;
            LOAD:      state_nxt = SEND;
            SEND:      state_nxt = frame_end ? WAIT_RESP : SEND;
            WAIT_RESP: state_nxt = (rx_done || tmo_hit) ? IDLE : WAIT_RESP;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;

    always_ff @(posedge clk) if (push) mem[wr_ptr] <= {cmd, data};

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovfl     <= 1'b0;
            TX       <= 1'b1;
            frm_snt  <= 1'b0;
            resp     <= 8'h00;
            resp_rdy <= 1'b0;
            timeout  <= 1'b0;
            frm      <= '0;
            bcnt     <= '0;
            bit_i    <= '0;
            byte_i   <= '0;
            tcnt     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count    <= count + (AW + 1)'(push) - (AW + 1)'(pop);
            if (snd_cmd && cmd_full) ovfl <= 1'b1;
            frm_snt  <= state == SEND && frame_end;
            timeout  <= tmo_hit && !rx_done;
            if (state == WAIT_RESP && rx_done) resp <= rx_sh;
            resp_rdy <= (state == WAIT_RESP && rx_done) || (resp_rdy && !clr_resp_rdy);
            tcnt     <= state == WAIT_RESP ? tcnt + TW'(1) : '0;
            if (state == LOAD) begin
                frm    <= frame_in;
                bcnt   <= '0;
                bit_i  <= '0;
                byte_i <= '0;
                TX     <= 1'b0;
            end else if (state == SEND) begin
                bcnt <= bit_end ? '0 : bcnt + BW'(1);
                if (bit_end) begin
                    bit_i <= bit_i == 4'd9 ? 4'd0 : bit_i + 4'd1;
                    if (bit_i == 4'd9) begin
                        byte_i <= byte_i + IW'(1);
                        frm    <= frm << 8;
                    end
                    // Bit 9 ends a byte: next is the following start bit, or idle after the last byte.
                    TX <= bit_i == 4'd9 ? byte_i == I_LAST : bit_i == 4'd8 ? 1'b1 : cur[bit_i[2:0]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync    <= 2'b11;
            rx_prev <= 1'b1;
            rx_on   <= 1'b0;
            rcnt    <= '0;
            rbit    <= '0;
            rx_sh   <= '0;
        end else begin
            sync    <= {sync[0], RX};
            rx_prev <= rx_s;
            if (!rx_on) begin
                rx_on <= rx_prev && !rx_s;
                rcnt  <= '0;
                rbit  <= '0;
            end else if (tmo_hit && !rx_done) begin
                rx_on <= 1'b0;
            end else begin
                rcnt <= r_end ? '0 : rcnt + BW'(1);
                if (r_end) begin
                    rbit <= rbit + 4'd1;
                    if (rbit == 4'd0 && rx_s) rx_on <= 1'b0;
                    if (rbit >= 4'd1 && rbit <= 4'd8) rx_sh <= {rx_s, rx_sh[7:1]};
                    if (rbit == 4'd9) rx_on <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_comm_master_q.sv
// tb_comm_master_q: directed tests for comm_master_q with a bench-side UART decoder and responder.
// Expected frame bytes include the checksum byte when COMM_MASTER_Q_CHKSUM_EN is defined.
module tb_comm_master_q;
    localparam int DB = 2;
    localparam int FD = 4;
    localparam int BD = 16;
    localparam int RT = 600;
`ifdef COMM_MASTER_Q_CHKSUM_EN
    localparam int NF = 4;
`else
    localparam int NF = 3;
`endif
    localparam int FRM = 2 + 10 * NF * BD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  cmd = 8'h00;
    logic [15:0] data = 16'h0000;
    logic        snd_cmd = 1'b0;
    logic        cmd_full, ovfl, busy, TX, frm_snt, resp_rdy, timeout;
    logic [2:0]  pending;
    logic        RX = 1'b1;
    logic [7:0]  resp;
    logic        clr_resp_rdy = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [7:0] txq[$];
    bit mon_en = 1'b0;

    comm_master_q #(.DATA_BYTES(DB), .FIFO_DEPTH(FD), .BAUD_DIV(BD), .RESP_TIMEOUT(RT)) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .data(data), .snd_cmd(snd_cmd),
        .cmd_full(cmd_full), .ovfl(ovfl), .pending(pending), .busy(busy),
        .TX(TX), .RX(RX), .frm_snt(frm_snt), .resp(resp), .resp_rdy(resp_rdy),
        .clr_resp_rdy(clr_resp_rdy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Decodes TX bytes at bit centres on the falling clock edge.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && TX === 1'b0) begin
                repeat (BD / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(negedge clk);
                    b[i] = TX;
                end
                repeat (BD) @(negedge clk);
                txq.push_back(b);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] frame_byte(input logic [7:0] c, input logic [15:0] d, input int k);
        return k == 0 ? c : k == 1 ? d[15:8] : k == 2 ? d[7:0] : 8'h00 - c - d[15:8] - d[7:0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        RX = 1'b0;
        repeat (BD) tick();
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BD) tick();
        end
        RX = stop;
        repeat (BD) tick();
        RX = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (TX !== 1'b1 || cmd_full !== 1'b0 || ovfl !== 1'b0 || pending !== 3'd0 || busy !== 1'b0)
            begin failures++; $display("FAIL reset_ctrl got TX=%b full=%b ovfl=%b pend=%0d busy=%b exp 1 0 0 0 0", TX, cmd_full, ovfl, pending, busy); end
        checks++;
        if (frm_snt !== 1'b0 || resp !== 8'h00 || resp_rdy !== 1'b0 || timeout !== 1'b0)
            begin failures++; $display("FAIL reset_resp got frm_snt=%b resp=%h rdy=%b tmo=%b exp 0 00 0 0", frm_snt, resp, resp_rdy, timeout); end
        rst = 1'b0;
        mon_en = 1'b1;
        tick();
    endtask

    task automatic test_frame;
        int n;
        logic [7:0] b;
        txq.delete();
        cmd = 8'h02; data = 16'h00FA; snd_cmd = 1'b1;
        tick();
        snd_cmd = 1'b0;
        checks++;
        if (busy !== 1'b1 || pending !== 3'd0)
            begin failures++; $display("FAIL frame_busy got busy=%b pend=%0d exp 1 0", busy, pending); end
        tick();
        checks++;
        if (TX !== 1'b0) begin failures++; $display("FAIL frame_start got TX=%b exp 0", TX); end
        n = 2;
        while (frm_snt !== 1'b1 && n < FRM + 100) begin tick(); n++; end
        checks++;
        if (n != FRM) begin failures++; $display("FAIL frame_frm_snt got cycle=%0d exp %0d", n, FRM); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL frame_wait_busy got %b exp 1", busy); end
        for (int k = 0; k < NF; k++) begin
            b = txq.size() > 0 ? txq.pop_front() : 8'hxx;
            checks++;
            if (b !== frame_byte(8'h02, 16'h00FA, k))
                begin failures++; $display("FAIL frame_byte%0d got %h exp %h", k, b, frame_byte(8'h02, 16'h00FA, k)); end
        end
        send_rx(8'hA5, 1'b1);
        tick();
        checks++;
        if (resp !== 8'hA5 || resp_rdy !== 1'b1 || busy !== 1'b0)
            begin failures++; $display("FAIL frame_resp got resp=%h rdy=%b busy=%b exp a5 1 0", resp, resp_rdy, busy); end
        repeat (5) tick();
        checks++;
        if (resp_rdy !== 1'b1) begin failures++; $display("FAIL resp_hold got %b exp 1", resp_rdy); end
        clr_resp_rdy = 1'b1;
        tick();
        clr_resp_rdy = 1'b0;
        checks++;
        if (resp_rdy !== 1'b0) begin failures++; $display("FAIL resp_clr got %b exp 0", resp_rdy); end
    endtask

    task automatic test_queue;
        logic [7:0]  qc[6] = '{8'h05, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        logic [15:0] qd[6] = '{16'h12FD, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        logic [7:0]  b;
        int n;
        txq.delete();
        for (int i = 0; i < 6; i++) begin
            cmd = qc[i]; data = qd[i]; snd_cmd = 1'b1;
            tick();
        end
        snd_cmd = 1'b0;
        checks++;
        if (pending !== 3'd4 || cmd_full !== 1'b1 || ovfl !== 1'b1)
            begin failures++; $display("FAIL queue_full got pend=%0d full=%b ovfl=%b exp 4 1 1", pending, cmd_full, ovfl); end
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (frm_snt !== 1'b1 && n < 3000) begin tick(); n++; end
            checks++;
            if (n >= 3000) begin failures++; $display("FAIL queue_frm%0d got no frm_snt exp pulse", i); end
            checks++;
            if (pending !== 3'(4 - i)) begin failures++; $display("FAIL queue_pending%0d got %0d exp %0d", i, pending, 4 - i); end
            send_rx(8'hC0 + 8'(i), 1'b1);
            tick();
            checks++;
            if (resp !== 8'hC0 + 8'(i) || resp_rdy !== 1'b1)
                begin failures++; $display("FAIL queue_resp%0d got %h/%b exp %h/1", i, resp, resp_rdy, 8'hC0 + 8'(i)); end
            clr_resp_rdy = 1'b1;
            tick();
            clr_resp_rdy = 1'b0;
        end
        for (int i = 0; i < 5; i++)
            for (int k = 0; k < NF; k++) begin
                b = txq.size() > 0 ? txq.pop_front() : 8'hxx;
                checks++;
                if (b !== frame_byte(qc[i], qd[i], k))
                    begin failures++; $display("FAIL queue_f%0d_b%0d got %h exp %h", i, k, b, frame_byte(qc[i], qd[i], k)); end
            end
        tick();
        checks++;
        if (busy !== 1'b0 || pending !== 3'd0 || cmd_full !== 1'b0 || ovfl !== 1'b1 || txq.size() != 0)
            begin failures++; $display("FAIL queue_drain got busy=%b pend=%0d full=%b ovfl=%b txq=%0d exp 0 0 0 1 0", busy, pending, cmd_full, ovfl, txq.size()); end
    endtask

    task automatic test_timeout;
        int n, m;
        logic [7:0] b;
        txq.delete();
        cmd = 8'h11; data = 16'h2233; snd_cmd = 1'b1;
        tick();
        cmd = 8'h44; data = 16'h5566;
        tick();
        snd_cmd = 1'b0;
        n = 0;
        while (frm_snt !== 1'b1 && n < 3000) begin tick(); n++; end
        checks++;
        if (n >= 3000) begin failures++; $display("FAIL tmo_frm got no frm_snt exp pulse"); end
        m = 0;
        while (timeout !== 1'b1 && m < RT + 100) begin tick(); m++; end
        checks++;
        if (m != RT) begin failures++; $display("FAIL tmo_delay got %0d exp %0d", m, RT); end
        checks++;
        if (busy !== 1'b0 || resp !== 8'hC4 || resp_rdy !== 1'b0)
            begin failures++; $display("FAIL tmo_state got busy=%b resp=%h rdy=%b exp 0 c4 0", busy, resp, resp_rdy); end
        tick();
        checks++;
        if (timeout !== 1'b0 || busy !== 1'b1 || pending !== 3'd0)
            begin failures++; $display("FAIL tmo_next got tmo=%b busy=%b pend=%0d exp 0 1 0", timeout, busy, pending); end
        tick();
        checks++;
        if (TX !== 1'b0) begin failures++; $display("FAIL tmo_next_start got TX=%b exp 0", TX); end
        n = 0;
        while (frm_snt !== 1'b1 && n < 3000) begin tick(); n++; end
        m = 0;
        while (timeout !== 1'b1 && m < RT + 100) begin tick(); m++; end
        checks++;
        if (n >= 3000 || m != RT) begin failures++; $display("FAIL tmo_second got frm=%0d tmo=%0d exp <3000 %0d", n, m, RT); end
        for (int k = 0; k < 2 * NF; k++) begin
            b = txq.size() > 0 ? txq.pop_front() : 8'hxx;
            checks++;
            if (b !== (k < NF ? frame_byte(8'h11, 16'h2233, k) : frame_byte(8'h44, 16'h5566, k - NF)))
                begin failures++; $display("FAIL tmo_byte%0d got %h exp %h", k, b, k < NF ? frame_byte(8'h11, 16'h2233, k) : frame_byte(8'h44, 16'h5566, k - NF)); end
        end
    endtask

    task automatic test_rx_errors;
        int n;
        cmd = 8'h33; data = 16'h0102; snd_cmd = 1'b1;
        tick();
        snd_cmd = 1'b0;
        n = 0;
        while (frm_snt !== 1'b1 && n < 3000) begin tick(); n++; end
        checks++;
        if (n >= 3000) begin failures++; $display("FAIL rxe_frm got no frm_snt exp pulse"); end
        RX = 1'b0;
        repeat (4) tick();
        RX = 1'b1;
        repeat (20) tick();
        send_rx(8'h0A, 1'b0);
        repeat (20) tick();
        checks++;
        if (resp_rdy !== 1'b0 || busy !== 1'b1 || resp !== 8'hC4)
            begin failures++; $display("FAIL rxe_ignore got rdy=%b busy=%b resp=%h exp 0 1 c4", resp_rdy, busy, resp); end
        send_rx(8'h3C, 1'b1);
        tick();
        checks++;
        if (resp !== 8'h3C || resp_rdy !== 1'b1 || busy !== 1'b0)
            begin failures++; $display("FAIL rxe_accept got resp=%h rdy=%b busy=%b exp 3c 1 0", resp, resp_rdy, busy); end
        repeat (200) tick();
        txq.delete();
    endtask

    task automatic test_reset_mid;
        bit saw_frm, saw_low;
        cmd = 8'h02; data = 16'h00FA; snd_cmd = 1'b1;
        tick();
        cmd = 8'h77; data = 16'h8899;
        tick();
        snd_cmd = 1'b0;
        repeat (2 * BD * 10 / 2 + 50) tick();
        checks++;
        if (TX !== 1'b0 || pending !== 3'd1)
            begin failures++; $display("FAIL rstm_before got TX=%b pend=%0d exp 0 1", TX, pending); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (TX !== 1'b1 || pending !== 3'd0 || busy !== 1'b0 || ovfl !== 1'b0 || resp !== 8'h00 || resp_rdy !== 1'b0)
            begin failures++; $display("FAIL rstm_after got TX=%b pend=%0d busy=%b ovfl=%b resp=%h rdy=%b exp 1 0 0 0 00 0", TX, pending, busy, ovfl, resp, resp_rdy); end
        saw_frm = 1'b0;
        saw_low = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (frm_snt === 1'b1) saw_frm = 1'b1;
            if (TX !== 1'b1) saw_low = 1'b1;
        end
        checks++;
        if (saw_frm || saw_low) begin failures++; $display("FAIL rstm_quiet got frm=%b txlow=%b exp 0 0", saw_frm, saw_low); end
        txq.delete();
    endtask

    initial begin
        test_reset();
        test_frame();
        test_queue();
        test_timeout();
        test_rx_errors();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
